// File: rtl/lzc_pkg.sv
// Shared definitions for the iterative leading-zero/leading-one counter.
//   lzc_state_e : scan FSM states
//   LZC_CLZ/CLO : values of the `mode` input
//   cnt_width() : width of a per-chunk count (never below one bit)
package lzc_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StScan,
    StDone
  } lzc_state_e;

  localparam logic LZC_CLZ = 1'b0;
  localparam logic LZC_CLO = 1'b1;

  function automatic int unsigned cnt_width(int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/lzc_chunk.sv
// Combinational priority encoder over one CHUNK-bit slice.
//   chunk : slice to examine, MSB first
//   zero  : all bits of the slice are clear
//   cnt   : leading zeros within the slice (meaningful only when zero = 0)
module lzc_chunk
  import lzc_pkg::*;
#(
  parameter int unsigned CHUNK = 4,
  localparam int unsigned CW = cnt_width(CHUNK)
) (
  input  logic [CHUNK-1:0] chunk,
  output logic             zero,
  output logic [CW-1:0]    cnt
);

  always_comb begin
    zero = ~|chunk;
    cnt  = '0;
    // Ascending scan: the most significant set bit is the last to write cnt.
    for (int unsigned i = 0; i < CHUNK; i++) begin
      if (chunk[i]) begin
        cnt = CW'(CHUNK - 1 - i);
      end
    end
  end

endmodule

// File: rtl/lzc_iter.sv
// Iterative leading-zero / leading-one counter with start/done handshake.
// Scans CHUNK bits per cycle from the MSB and stops at the first non-empty chunk.
//   clk, rst : clock, asynchronous active-high reset
//   start    : request, sampled while not busy (IDLE or DONE)
//   mode     : 0 = CLZ, 1 = CLO, sampled with start
//   a        : operand, sampled with start
//   busy     : scan in progress
//   done     : one-cycle pulse, r valid from this cycle on
//   r        : result count, held until the next accepted start
module lzc_iter
  import lzc_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CHUNK = 4,
  localparam int unsigned RW = $clog2(WIDTH + 1),
  localparam int unsigned CW = cnt_width(CHUNK)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  output logic             busy,
  output logic             done,
  output logic [RW-1:0]    r
);

  lzc_state_e       state_q, state_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic [RW-1:0]    cnt_q, cnt_d;
  logic [RW-1:0]    r_q, r_d;

  logic             chunk_zero;
  logic [CW-1:0]    chunk_cnt;

  lzc_chunk #(
    .CHUNK (CHUNK)
  ) u_chunk (
    .chunk (sreg_q[WIDTH-1 -: CHUNK]),
    .zero  (chunk_zero),
    .cnt   (chunk_cnt)
  );

  always_comb begin
    state_d = state_q;
    sreg_d  = sreg_q;
    cnt_d   = cnt_q;
    r_d     = r_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          // CLO is CLZ of the inverted operand, so the core only counts zeros.
          sreg_d  = (mode == LZC_CLO) ? ~a : a;
          cnt_d   = '0;
          state_d = StScan;
        end else begin
          state_d = StIdle;
        end
      end
      StScan: begin
        if (chunk_zero) begin
          cnt_d  = cnt_q + RW'(CHUNK);
          sreg_d = sreg_q << CHUNK;
          if (cnt_d == RW'(WIDTH)) begin
            r_d     = RW'(WIDTH);
            state_d = StDone;
          end
        end else begin
          r_d     = cnt_q + RW'(chunk_cnt);
          state_d = StDone;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      sreg_q  <= '0;
      cnt_q   <= '0;
      r_q     <= '0;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      cnt_q   <= cnt_d;
      r_q     <= r_d;
    end
  end

  // Decoded straight from the state register: no input-to-output path.
  assign busy = (state_q == StScan);
  assign done = (state_q == StDone);
  assign r    = r_q;

endmodule

// File: tb/tb_lzc_iter.sv
module tb_lzc_iter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        start0 = 1'b0;
  logic        mode0  = 1'b0;
  logic [31:0] a0     = '0;
  logic        busy0, done0;
  logic [5:0]  r0;

  logic        start1 = 1'b0;
  logic        mode1  = 1'b0;
  logic [15:0] a1     = '0;
  logic        busy1, done1;
  logic [4:0]  r1;

  int n_assert = 0;
  int n_fail   = 0;
  int lat_cnt  = 0;
  int overlap  = 0;

  always #5 clk = ~clk;

  lzc_iter #(
    .WIDTH (32),
    .CHUNK (4)
  ) u_dut32 (
    .clk   (clk),
    .rst   (rst),
    .start (start0),
    .mode  (mode0),
    .a     (a0),
    .busy  (busy0),
    .done  (done0),
    .r     (r0)
  );

  lzc_iter #(
    .WIDTH (16),
    .CHUNK (8)
  ) u_dut16 (
    .clk   (clk),
    .rst   (rst),
    .start (start1),
    .mode  (mode1),
    .a     (a1),
    .busy  (busy1),
    .done  (done1),
    .r     (r1)
  );

  // Reference: count MSB-first bits equal to the counted value.
  function automatic int ref_lz(logic [31:0] v, int w, logic md);
    int n = 0;
    for (int i = w - 1; i >= 0; i--) begin
      if (v[i] != md) break;
      n++;
    end
    return n;
  endfunction

  function automatic int ref_lat(int lz, int w, int c);
    int k = lz / c + 1;
    return (k < w / c) ? k : w / c;
  endfunction

  function automatic logic obs_busy(int inst);
    return (inst == 0) ? busy0 : busy1;
  endfunction

  function automatic logic obs_done(int inst);
    return (inst == 0) ? done0 : done1;
  endfunction

  function automatic logic [31:0] obs_r(int inst);
    return (inst == 0) ? {26'd0, r0} : {27'd0, r1};
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    lat_cnt++;
  endtask

  // Present a request now; it is accepted at the next rising edge.
  task automatic issue(int inst, logic [31:0] av, logic md);
    if (inst == 0) begin
      a0 = av; mode0 = md; start0 = 1'b1;
    end else begin
      a1 = av[15:0]; mode1 = md; start1 = 1'b1;
    end
    @(posedge clk);
    #1;
    lat_cnt = 0;
    start0  = 1'b0;
    start1  = 1'b0;
    check("accept busy", {31'd0, obs_busy(inst)}, 32'd1);
    check("accept done", {31'd0, obs_done(inst)}, 32'd0);
  endtask

  task automatic wait_done(int inst, int exp_r, int exp_lat, string tag);
    logic got = 1'b0;
    int   guard = 0;
    while (!got && guard < 40) begin
      tick();
      guard++;
      if (obs_busy(inst) && obs_done(inst)) overlap++;
      if (obs_done(inst)) got = 1'b1;
    end
    check({tag, " done"}, {31'd0, got}, 32'd1);
    if (got) begin
      check({tag, " lat"}, lat_cnt, exp_lat);
      check({tag, " r"}, obs_r(inst), exp_r);
      check({tag, " busy"}, {31'd0, obs_busy(inst)}, 32'd0);
    end
  endtask

  task automatic run(int inst, logic [31:0] av, logic md, int w, int c, string tag);
    int lz = ref_lz(av, w, md);
    issue(inst, av, md);
    wait_done(inst, lz, ref_lat(lz, w, c), tag);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int seen;
    logic [31:0] av;
    logic        md;
    int          sh;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst busy", {31'd0, busy0}, 32'd0);
    check("rst done", {31'd0, done0}, 32'd0);
    check("rst r", {26'd0, r0}, 32'd0);
    check("rst busy16", {31'd0, busy1}, 32'd0);
    rst = 1'b0;
    tick();

    // Directed cases
    run(0, 32'h0000F000, 1'b0, 32, 4, "clz mid");
    check("clz mid expected", {26'd0, r0}, 32'd16);
    tick();
    check("done pulse drops", {31'd0, done0}, 32'd0);
    check("r held", {26'd0, r0}, 32'd16);
    run(0, 32'h7FFFFFFF, 1'b0, 32, 4, "clz min");
    run(0, 32'h00000000, 1'b0, 32, 4, "clz zero");
    run(0, 32'h07FFFFFF, 1'b0, 32, 4, "clz five");
    run(0, 32'hFFFFFFFF, 1'b1, 32, 4, "clo ones");
    run(0, 32'h87777777, 1'b1, 32, 4, "clo one");
    run(0, 32'h77777777, 1'b1, 32, 4, "clo none");

    // Start during scan is ignored
    issue(0, 32'h00000000, 1'b0);
    tick();
    a0 = 32'h00000001; start0 = 1'b1;
    tick();
    start0 = 1'b0; a0 = 32'hFFFFFFFF;
    wait_done(0, 32, 8, "ignored start");

    // Back-to-back: next request presented in the done cycle
    issue(0, 32'h00010000, 1'b0);
    wait_done(0, 15, 4, "b2b first");
    issue(0, 32'h00300000, 1'b0);
    wait_done(0, 10, 3, "b2b second");

    // Reset mid-scan
    issue(0, 32'h00000000, 1'b0);
    repeat (3) tick();
    rst = 1'b1;
    #1;
    check("midrst busy", {31'd0, busy0}, 32'd0);
    check("midrst done", {31'd0, done0}, 32'd0);
    check("midrst r", {26'd0, r0}, 32'd0);
    tick();
    rst  = 1'b0;
    seen = 0;
    repeat (12) begin
      tick();
      if (done0) seen++;
    end
    check("midrst no done", seen, 0);
    run(0, 32'h00F00000, 1'b0, 32, 4, "after rst");

    // Parameter variant
    run(1, 32'h000000FF, 1'b0, 16, 8, "w16 ff");
    run(1, 32'h00000000, 1'b0, 16, 8, "w16 zero");
    run(1, 32'h0000FFF0, 1'b1, 16, 8, "w16 clo");

    // Random operands against the reference model
    for (int i = 0; i < 30; i++) begin
      av = $urandom;
      sh = $urandom_range(0, 32);
      av = (sh == 32) ? 32'd0 : av >> sh;
      md = 1'($urandom_range(0, 1));
      if (md) av = ~av;
      run(0, av, md, 32, 4, "rand32");
    end
    for (int i = 0; i < 10; i++) begin
      av = $urandom;
      sh = $urandom_range(0, 16);
      av = (av & 32'h0000FFFF) >> sh;
      md = 1'($urandom_range(0, 1));
      if (md) av = ~av;
      run(1, av, md, 16, 8, "rand16");
    end

    check("busy/done overlap", overlap, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
